// File: rtl/user_io_pkg.sv
// -----------------------------------------------------------------------------
// user_io_pkg
// Shared definitions for the user I/O pad controller:
//   - register offsets within the 256-byte Wishbone window
//   - reset values of the architectural registers
//   - word-index helper that tells a LO word (bits 31:0) from a HI word
//     (bits 63:32) of a 64-bit register pair
// Optional feature macro used by the importing files: USER_IO_LOOPBACK_EN
// -----------------------------------------------------------------------------
package user_io_pkg;

    localparam int WORD_W = 32;
    localparam int REG_W  = 64;

    // Register offsets (byte address bits 7:0)
    localparam logic [7:0] OFF_OUT_LO      = 8'h00;
    localparam logic [7:0] OFF_OUT_HI      = 8'h04;
    localparam logic [7:0] OFF_OEB_LO      = 8'h08;
    localparam logic [7:0] OFF_OEB_HI      = 8'h0C;
    localparam logic [7:0] OFF_IN_LO       = 8'h10;
    localparam logic [7:0] OFF_IN_HI       = 8'h14;
    localparam logic [7:0] OFF_IRQ_EN_LO   = 8'h18;
    localparam logic [7:0] OFF_IRQ_EN_HI   = 8'h1C;
    localparam logic [7:0] OFF_IRQ_STAT_LO = 8'h20;
    localparam logic [7:0] OFF_IRQ_STAT_HI = 8'h24;
    localparam logic [7:0] OFF_EDGE_LO     = 8'h28;
    localparam logic [7:0] OFF_EDGE_HI     = 8'h2C;
    localparam logic [7:0] OFF_CTRL        = 8'h30;

    // Reset values before masking to the implemented pin count
    localparam logic [REG_W-1:0] RST_OUT      = '0;
    localparam logic [REG_W-1:0] RST_OEB      = '1;  // every pad an input
    localparam logic [REG_W-1:0] RST_IRQ_EN   = '0;
    localparam logic [REG_W-1:0] RST_IRQ_STAT = '0;
    localparam logic [REG_W-1:0] RST_EDGE     = '1;  // every pin rising-edge
    localparam logic             RST_CTRL     = 1'b0;

    // 1 when the low offset bits address the HI word of an aligned pair.
    function automatic logic word_idx(input logic [2:0] off_lo);
        return off_lo[2] & (off_lo[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/user_io_sync.sv
// -----------------------------------------------------------------------------
// user_io_sync
// Multi-flop synchroniser for asynchronous pad inputs followed by a one-cycle
// delayed copy, producing per-bit rising and falling edge strobes.
// The chain carries pure data and is not reset; it flushes itself within
// SYNC_STAGES+1 clocks.
// Ports:
//   i_clk   clock
//   i_d     asynchronous input bits            [WIDTH]
//   o_q     synchronised value (last stage)    [WIDTH]
//   o_rise  o_q & ~previous o_q                [WIDTH]
//   o_fall  ~o_q & previous o_q                [WIDTH]
// -----------------------------------------------------------------------------
module user_io_sync #(
    parameter int WIDTH       = 38,
    parameter int SYNC_STAGES = 2
) (
    input  logic             i_clk,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q,
    output logic [WIDTH-1:0] o_rise,
    output logic [WIDTH-1:0] o_fall
);

    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [WIDTH-1:0] r_prev;

    // Synchroniser chain, then one delayed copy of the settled value
    always_ff @(posedge i_clk) begin
        r_sync[0] <= i_d;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            r_sync[i] <= r_sync[i-1];
        end
        r_prev <= r_sync[SYNC_STAGES-1];
    end

    assign o_q    = r_sync[SYNC_STAGES-1];
    assign o_rise = r_sync[SYNC_STAGES-1] & ~r_prev;
    assign o_fall = ~r_sync[SYNC_STAGES-1] & r_prev;

endmodule

// File: rtl/user_io_ctrl.sv
// -----------------------------------------------------------------------------
// user_io_ctrl
// Wishbone-mapped controller for the user I/O pads: per-pin output data,
// active-low output enable, synchronised input readback and edge-detect
// interrupts reported on user_irq[0].
// Optional feature: define USER_IO_LOOPBACK_EN to implement CTRL[0] (LOOP),
// which drives io_out from the synchronised inputs and reports LOOP on
// user_irq[1]. Without the macro CTRL reads 0 and io_out always follows OUT.
// Ports:
//   wb_clk_i            clock
//   wb_rst_i            synchronous active-high reset
//   wbs_stb_i/cyc_i/we_i Wishbone classic strobe / cycle / write enable
//   wbs_sel_i   [4]     byte selects
//   wbs_dat_i   [32]    write data
//   wbs_adr_i   [32]    byte address
//   wbs_ack_o           registered one-cycle acknowledge
//   wbs_dat_o   [32]    registered read data, 0 outside the ack cycle
//   io_in       [NUM_IO] asynchronous pad inputs
//   io_out      [NUM_IO] pad output data
//   io_oeb      [NUM_IO] pad output enable, active-low
//   user_irq    [3]     {0, LOOP, edge interrupt}
// -----------------------------------------------------------------------------
module user_io_ctrl
    import user_io_pkg::*;
#(
    parameter int          NUM_IO      = 38,
    parameter logic [31:0] ADDR_BASE   = 32'h3000_0000,
    parameter int          SYNC_STAGES = 2
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_dat_i,
    input  logic [31:0]       wbs_adr_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    input  logic [NUM_IO-1:0] io_in,
    output logic [NUM_IO-1:0] io_out,
    output logic [NUM_IO-1:0] io_oeb,
    output logic [2:0]        user_irq
);

    // Mask of the pins that exist; bits at or above NUM_IO are held at 0
    // in every register, so they read back 0 and writes leave them alone.
    localparam logic [REG_W-1:0] VALID_MASK =
        (NUM_IO >= REG_W) ? {REG_W{1'b1}} : ((64'd1 << NUM_IO) - 64'd1);

    // Architectural registers, always held at full 64-bit width
    logic [REG_W-1:0]  r_out;
    logic [REG_W-1:0]  r_oeb;
    logic [REG_W-1:0]  r_irq_en;
    logic [REG_W-1:0]  r_irq_stat;
    logic [REG_W-1:0]  r_edge;
    logic              r_irq0;
    logic              r_ack;
    logic [WORD_W-1:0] r_dat;

    logic [NUM_IO-1:0] w_in;
    logic [NUM_IO-1:0] w_rise;
    logic [NUM_IO-1:0] w_fall;
    logic [REG_W-1:0]  w_in64;
    logic [REG_W-1:0]  w_rise64;
    logic [REG_W-1:0]  w_fall64;
    logic [REG_W-1:0]  w_evt64;
    logic [REG_W-1:0]  w_clr64;
    logic [WORD_W-1:0] w_bmask;
    logic [WORD_W-1:0] w_rdata;
    logic [7:0]        w_off;
    logic              w_hit;
    logic              w_wr;
    logic              w_rd;
    logic              w_hi;
    logic              w_stat_wr;
    logic              w_loop;

    // Byte-masked update of one 32-bit half of a 64-bit register pair.
    function automatic logic [REG_W-1:0] merge_word(
        input logic [REG_W-1:0]  cur,
        input logic              hi,
        input logic [WORD_W-1:0] dat,
        input logic [WORD_W-1:0] bm
    );
        logic [REG_W-1:0] res;
        res = cur;
        if (hi) begin
            res[63:32] = (cur[63:32] & ~bm) | (dat & bm);
        end else begin
            res[31:0]  = (cur[31:0] & ~bm) | (dat & bm);
        end
        return res & VALID_MASK;
    endfunction

    // ------------------------------------------------------------------
    // Input synchroniser and edge detection
    // ------------------------------------------------------------------
    user_io_sync #(
        .WIDTH       (NUM_IO),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .i_clk  (wb_clk_i),
        .i_d    (io_in),
        .o_q    (w_in),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    always_comb begin
        w_in64   = '0;
        w_rise64 = '0;
        w_fall64 = '0;
        w_in64[NUM_IO-1:0]   = w_in;
        w_rise64[NUM_IO-1:0] = w_rise;
        w_fall64[NUM_IO-1:0] = w_fall;
    end

    // EDGE selects, per pin, which transition raises the status bit
    assign w_evt64 = (r_edge & w_rise64) | (~r_edge & w_fall64);

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    // Gating on !ack keeps a strobe that is still high during the ack cycle
    // from being taken as a second access.
    assign w_hit   = wbs_stb_i & wbs_cyc_i & ~r_ack &
                     (wbs_adr_i[31:8] == ADDR_BASE[31:8]);
    assign w_wr    = w_hit & wbs_we_i;
    assign w_rd    = w_hit & ~wbs_we_i;
    assign w_off   = wbs_adr_i[7:0];
    assign w_hi    = word_idx(w_off[2:0]);
    assign w_bmask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}},
                      {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};

    assign w_stat_wr = w_wr & ((w_off == OFF_IRQ_STAT_LO) | (w_off == OFF_IRQ_STAT_HI));

    always_comb begin
        w_clr64 = '0;
        if (w_stat_wr) begin
            if (w_hi) begin
                w_clr64[63:32] = wbs_dat_i & w_bmask;
            end else begin
                w_clr64[31:0]  = wbs_dat_i & w_bmask;
            end
        end
        w_clr64 = w_clr64 & VALID_MASK;
    end

    always_comb begin
        w_rdata = '0;
        case (w_off)
            OFF_OUT_LO:      w_rdata = r_out[31:0];
            OFF_OUT_HI:      w_rdata = r_out[63:32];
            OFF_OEB_LO:      w_rdata = r_oeb[31:0];
            OFF_OEB_HI:      w_rdata = r_oeb[63:32];
            OFF_IN_LO:       w_rdata = w_in64[31:0];
            OFF_IN_HI:       w_rdata = w_in64[63:32];
            OFF_IRQ_EN_LO:   w_rdata = r_irq_en[31:0];
            OFF_IRQ_EN_HI:   w_rdata = r_irq_en[63:32];
            OFF_IRQ_STAT_LO: w_rdata = r_irq_stat[31:0];
            OFF_IRQ_STAT_HI: w_rdata = r_irq_stat[63:32];
            OFF_EDGE_LO:     w_rdata = r_edge[31:0];
            OFF_EDGE_HI:     w_rdata = r_edge[63:32];
            OFF_CTRL:        w_rdata = {31'd0, w_loop};
            default:         w_rdata = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Register file, handshake and interrupt output
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_ack      <= 1'b0;
            r_dat      <= '0;
            r_irq0     <= 1'b0;
            r_out      <= RST_OUT & VALID_MASK;
            r_oeb      <= RST_OEB & VALID_MASK;
            r_irq_en   <= RST_IRQ_EN & VALID_MASK;
            r_irq_stat <= RST_IRQ_STAT & VALID_MASK;
            r_edge     <= RST_EDGE & VALID_MASK;
        end else begin
            r_ack <= w_hit;
            r_dat <= w_rd ? w_rdata : '0;

            // A new event wins over a W1C of the same bit in the same cycle
            r_irq_stat <= ((r_irq_stat & ~w_clr64) | w_evt64) & VALID_MASK;

            // Sees the status one clock after it was updated
            r_irq0 <= |(r_irq_stat & r_irq_en);

            if (w_wr) begin
                case (w_off)
                    OFF_OUT_LO, OFF_OUT_HI:
                        r_out <= merge_word(r_out, w_hi, wbs_dat_i, w_bmask);
                    OFF_OEB_LO, OFF_OEB_HI:
                        r_oeb <= merge_word(r_oeb, w_hi, wbs_dat_i, w_bmask);
                    OFF_IRQ_EN_LO, OFF_IRQ_EN_HI:
                        r_irq_en <= merge_word(r_irq_en, w_hi, wbs_dat_i, w_bmask);
                    OFF_EDGE_LO, OFF_EDGE_HI:
                        r_edge <= merge_word(r_edge, w_hi, wbs_dat_i, w_bmask);
                    default: ;
                endcase
            end
        end
    end

`ifdef USER_IO_LOOPBACK_EN
    logic r_loop;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_loop <= RST_CTRL;
        end else if (w_wr && (w_off == OFF_CTRL) && wbs_sel_i[0]) begin
            r_loop <= wbs_dat_i[0];
        end
    end

    assign w_loop = r_loop;
    assign io_out = r_loop ? w_in : r_out[NUM_IO-1:0];
`else
    assign w_loop = 1'b0;
    assign io_out = r_out[NUM_IO-1:0];
`endif

    assign io_oeb    = r_oeb[NUM_IO-1:0];
    assign wbs_ack_o = r_ack;
    assign wbs_dat_o = r_dat;
    assign user_irq  = {1'b0, w_loop, r_irq0};

endmodule

// File: tb/tb_user_io_ctrl.sv
module tb_user_io_ctrl;

    localparam int          NUM_IO = 38;
    localparam logic [31:0] BASE   = 32'h3000_0000;
    localparam logic [63:0] MASK   = (64'd1 << NUM_IO) - 64'd1;

    logic              clk = 1'b0;
    logic              rst;
    logic              stb, cyc, we;
    logic [3:0]        sel;
    logic [31:0]       dat_i, adr;
    logic              ack;
    logic [31:0]       dat_o;
    logic [NUM_IO-1:0] io_in;
    logic [NUM_IO-1:0] io_out;
    logic [NUM_IO-1:0] io_oeb;
    logic [2:0]        user_irq;

    int checks = 0;
    int errors = 0;

    // Reference model state (64-bit views, bits >= NUM_IO always 0)
    logic [63:0] m_out, m_oeb, m_en, m_stat, m_edge, m_in;
    logic        m_loop;

    logic [31:0] rd;
    int          lat;
    int          op;
    logic [7:0]  off;
    logic        irq_at_ack;

    always #5 clk = ~clk;

    user_io_ctrl #(
        .NUM_IO      (NUM_IO),
        .ADDR_BASE   (BASE),
        .SYNC_STAGES (2)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wbs_stb_i (stb),
        .wbs_cyc_i (cyc),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_dat_i (dat_i),
        .wbs_adr_i (adr),
        .wbs_ack_o (ack),
        .wbs_dat_o (dat_o),
        .io_in     (io_in),
        .io_out    (io_out),
        .io_oeb    (io_oeb),
        .user_irq  (user_irq)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] bytemask(input logic [3:0] s);
        return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    endfunction

    function automatic logic [63:0] put(input logic [63:0] v, input logic hi,
                                        input logic [31:0] d, input logic [31:0] bm);
        logic [63:0] r;
        r = v;
        if (hi) r[63:32] = (v[63:32] & ~bm) | (d & bm);
        else    r[31:0]  = (v[31:0] & ~bm) | (d & bm);
        return r & MASK;
    endfunction

    task automatic m_write(input logic [7:0] o, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] bm;
        logic [63:0] lane;
        bm   = bytemask(s);
        lane = o[2] ? {d & bm, 32'h0} : {32'h0, d & bm};
        case (o)
            8'h00, 8'h04: m_out  = put(m_out,  o[2], d, bm);
            8'h08, 8'h0C: m_oeb  = put(m_oeb,  o[2], d, bm);
            8'h18, 8'h1C: m_en   = put(m_en,   o[2], d, bm);
            8'h20, 8'h24: m_stat = m_stat & ~(lane & MASK);
            8'h28, 8'h2C: m_edge = put(m_edge, o[2], d, bm);
`ifdef USER_IO_LOOPBACK_EN
            8'h30:        if (s[0]) m_loop = d[0];
`endif
            default: ;
        endcase
    endtask

    function automatic logic [31:0] half(input logic [63:0] v, input logic hi);
        return hi ? v[63:32] : v[31:0];
    endfunction

    function automatic logic [31:0] m_read(input logic [7:0] o);
        case (o)
            8'h00, 8'h04: return half(m_out,  o[2]);
            8'h08, 8'h0C: return half(m_oeb,  o[2]);
            8'h10, 8'h14: return half(m_in,   o[2]);
            8'h18, 8'h1C: return half(m_en,   o[2]);
            8'h20, 8'h24: return half(m_stat, o[2]);
            8'h28, 8'h2C: return half(m_edge, o[2]);
            8'h30:        return {31'd0, m_loop};
            default:      return 32'h0;
        endcase
    endfunction

    // Pin events per edge-select rules: rising where EDGE=1, falling where EDGE=0
    task automatic m_pins(input logic [63:0] nv);
        logic [63:0] r, f;
        r = nv & ~m_in;
        f = ~nv & m_in;
        m_stat = m_stat | (((r & m_edge) | (f & ~m_edge)) & MASK);
        m_in = nv & MASK;
    endtask

    function automatic logic [NUM_IO-1:0] exp_out();
        logic [63:0] v;
        v = m_loop ? m_in : m_out;
        return v[NUM_IO-1:0];
    endfunction

    // ---------------- bus helpers ----------------
    // Must be entered on a falling edge; returns 1 ns after the clock that
    // follows the ack (or after 16 clocks with no ack, lat = 0).
    task automatic wb_core(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] r, output int l);
        stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat_i = d; sel = s;
        l = 0; r = '0;
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk); #1;
            if (ack) begin
                l = i; r = dat_o; irq_at_ack = user_irq[0];
                break;
            end
        end
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        if (l != 0) begin
            @(posedge clk); #1;
            chk("ack_pulse_len", {63'd0, ack}, 64'd0);
            chk("dat_idle_zero", {32'd0, dat_o}, 64'd0);
        end
    endtask

    task automatic bus_wr(input logic [7:0] o, input logic [31:0] d, input logic [3:0] s);
        @(negedge clk);
        wb_core(1'b1, BASE | {24'd0, o}, d, s, rd, lat);
        chk("wr_ack_latency", 64'(lat), 64'd1);
        m_write(o, d, s);
    endtask

    task automatic bus_rd_chk(input logic [7:0] o);
        @(negedge clk);
        wb_core(1'b0, BASE | {24'd0, o}, 32'h0, 4'hF, rd, lat);
        chk("rd_ack_latency", 64'(lat), 64'd1);
        chk($sformatf("read_%02h", o), {32'd0, rd}, {32'd0, m_read(o)});
    endtask

    task automatic drive_io(input logic [63:0] v);
        @(negedge clk);
        io_in = v[NUM_IO-1:0];
        m_pins(v & MASK);
    endtask

    task automatic set_io(input logic [63:0] v);
        drive_io(v);
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic chk_pins();
        chk("io_out", {26'd0, io_out}, {26'd0, exp_out()});
        chk("io_oeb", {26'd0, io_oeb}, m_oeb & MASK);
        chk("user_irq", {61'd0, user_irq}, {61'd0, 1'b0, m_loop, |(m_stat & m_en)});
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0;
        dat_i = '0; adr = '0; io_in = '0; irq_at_ack = 1'b0;
        m_out = '0; m_oeb = MASK; m_en = '0; m_stat = '0; m_edge = MASK;
        m_in = '0; m_loop = 1'b0;

        // 1. Reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_io_oeb", {26'd0, io_oeb}, MASK);
        chk("rst_io_out", {26'd0, io_out}, 64'd0);
        chk("rst_user_irq", {61'd0, user_irq}, 64'd0);
        chk("rst_ack", {63'd0, ack}, 64'd0);
        chk("rst_dat", {32'd0, dat_o}, 64'd0);
        bus_rd_chk(8'h08);
        chk("rst_oeb_lo_value", {32'd0, rd}, 64'hFFFF_FFFF);
        bus_rd_chk(8'h0C);
        bus_rd_chk(8'h28);
        bus_rd_chk(8'h20);

        // 2. Byte-select write
        bus_wr(8'h00, 32'hA5A5_A5A5, 4'b0011);
        bus_rd_chk(8'h00);
        chk("bytesel_value", {32'd0, rd}, 64'h0000_A5A5);
        chk("bytesel_io_out", {48'd0, io_out[15:0]}, 64'hA5A5);

        // 3. Rising-edge interrupt and W1C
        bus_wr(8'h18, 32'h1, 4'hF);
        drive_io(m_in | 64'h1);
        repeat (3) @(posedge clk);
        #1;
        chk("irq_not_yet_at_3", {63'd0, user_irq[0]}, 64'd0);
        @(posedge clk); #1;
        chk("irq_at_4", {63'd0, user_irq[0]}, 64'd1);
        bus_rd_chk(8'h20);
        chk("stat0_set", {63'd0, rd[0]}, 64'd1);
        bus_wr(8'h20, 32'h1, 4'hF);
        chk("irq_at_w1c_ack", {63'd0, irq_at_ack}, 64'd1);
        chk("irq_after_w1c", {63'd0, user_irq[0]}, 64'd0);

        // 4. Set beats clear
        set_io(m_in | 64'h20);
        bus_wr(8'h20, 32'h20, 4'hF);
        bus_wr(8'h28, 32'hFFFF_FFDF, 4'hF);
        drive_io(m_in & ~64'h20);
        @(negedge clk);
        @(negedge clk);
        wb_core(1'b1, BASE | 32'h20, 32'h20, 4'hF, rd, lat);
        chk("race_w1c_ack", 64'(lat), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        bus_rd_chk(8'h20);
        chk("stat5_survives", {63'd0, rd[5]}, 64'd1);

        // 5. Decode and width
        bus_wr(8'h04, 32'hFFFF_FFFF, 4'hF);
        bus_rd_chk(8'h04);
        chk("out_hi_width", {32'd0, rd}, 64'h3F);
        bus_wr(8'h14, 32'hFFFF_FFFF, 4'hF);
        bus_rd_chk(8'h14);
        @(negedge clk);
        wb_core(1'b0, 32'h3000_0100, 32'h0, 4'hF, rd, lat);
        chk("out_of_window_no_ack", 64'(lat), 64'd0);
        @(negedge clk);
        wb_core(1'b1, 32'h3000_0040, 32'hFFFF_FFFF, 4'hF, rd, lat);
        chk("unmapped_wr_ack", 64'(lat), 64'd1);
        @(negedge clk);
        wb_core(1'b0, 32'h3000_0040, 32'h0, 4'hF, rd, lat);
        chk("unmapped_rd_ack", 64'(lat), 64'd1);
        chk("unmapped_rd_zero", {32'd0, rd}, 64'd0);
        chk_pins();

        // Randomised register and pin traffic against the model
        for (int it = 0; it < 80; it++) begin
            op  = int'($urandom_range(0, 3));
            off = 8'(4 * $urandom_range(0, 15));
            case (op)
                0: bus_wr(off, $urandom, 4'($urandom_range(0, 15)));
                1: bus_rd_chk(off);
                2: set_io(({$urandom, $urandom} & {$urandom, $urandom}) & MASK);
                default: bus_wr(8'(($urandom_range(0, 1) != 0) ? 8'h24 : 8'h20), $urandom, 4'hF);
            endcase
            chk_pins();
        end

        // 6. Loopback
        bus_wr(8'h30, 32'h1, 4'hF);
        bus_rd_chk(8'h30);
`ifdef USER_IO_LOOPBACK_EN
        drive_io(64'h15);
        repeat (2) @(posedge clk);
        #1;
        chk("loop_io_out", {26'd0, io_out}, 64'h15);
        chk("loop_irq1", {63'd0, user_irq[1]}, 64'd1);
        repeat (3) @(posedge clk);
        #1;
        chk_pins();
        bus_wr(8'h30, 32'h0, 4'hF);
        chk_pins();
`else
        set_io(64'h15);
        chk("noloop_io_out", {26'd0, io_out}, {26'd0, m_out[NUM_IO-1:0]});
        chk("noloop_irq1", {63'd0, user_irq[1]}, 64'd0);
        chk_pins();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
